hpm_counters: RTL and testbench

HPM_COUNTERS -- requirements
Module: hpm_counters

---
 rtl/hpm_counters.sv | 225 ++++++++++++++++++++++
 tb/tb_hpm_counters.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpm_counters.sv
// Machine/user hardware performance counters behind a CSR access port.
// Optional sticky overflow flag ovf_irq_o is enabled by defining HPM_OVF_IRQ_EN.
package hpm_pkg;
  typedef logic [11:0] csr_addr_t;
  typedef enum logic [1:0] {
    CSR_READ  = 2'd0,
    CSR_WRITE = 2'd1,
    CSR_SET   = 2'd2,
    CSR_CLEAR = 2'd3
  } csr_operation_t;
endpackage

module hpm_counters
  import hpm_pkg::*;
#(
  parameter int NUM_HPM    = 4,
  parameter int CNT_WIDTH  = 64,
  parameter int NUM_EVENTS = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  csr_access_i,
  input  csr_addr_t             csr_addr_i,
  input  logic [1:0]            csr_op_i,
  input  logic [31:0]           csr_wdata_i,
  output logic [31:0]           csr_rdata_o,
  output logic                  csr_hit_o,
  output logic                  csr_illegal_o,
  input  logic                  instr_retired_i,
  input  logic [NUM_EVENTS-1:0] event_i
`ifdef HPM_OVF_IRQ_EN
  ,
  output logic                  ovf_irq_o
`endif
);
  localparam int LAST = 2 + NUM_HPM;
  localparam int HW   = CNT_WIDTH - 32;
  localparam logic [63:0] INH_ONES =
    (64'd1 << (LAST + 1)) - 64'd1;
  localparam logic [31:0] INH_MASK =
    32'(INH_ONES) & ~32'h2;

  csr_operation_t op;
  logic [4:0]  idx;
  logic [6:0]  blk;
  logic        cnt_ok;
  logic        evt_ok;
  logic        sel_lo;
  logic        sel_hi;
  logic        sel_inh;
  logic        sel_evt;
  logic        sel_ro;
  logic        hit;
  logic        does_wr;
  logic        we;
  logic [31:0] rdata;
  logic [31:0] wval;
  logic [63:0] cnt_ext;
  logic [31:0] inh;

  logic [CNT_WIDTH-1:0]  cnt [32];
  logic [NUM_EVENTS-1:0] evt [32];
`ifdef HPM_OVF_IRQ_EN
  logic [31:0] wrap;
`endif

  assign op  = csr_operation_t'(csr_op_i);
  assign idx = csr_addr_i[4:0];
  assign blk = csr_addr_i[11:5];

  assign evt_ok = (int'(idx) >= 3)
               && (int'(idx) <= LAST);
  assign cnt_ok = (idx == 5'd0)
               || (idx == 5'd2)
               || evt_ok;

  // 32-entry address blocks: B00, B80, C00, C80, 320
  always_comb begin
    sel_lo  = 1'b0;
    sel_hi  = 1'b0;
    sel_inh = 1'b0;
    sel_evt = 1'b0;
    sel_ro  = 1'b0;
    unique case (1'b1)
      blk == 7'h58: sel_lo = cnt_ok;
      blk == 7'h5C: sel_hi = cnt_ok;
      blk == 7'h60: begin
        sel_lo = cnt_ok;
        sel_ro = cnt_ok;
      end
      blk == 7'h64: begin
        sel_hi = cnt_ok;
        sel_ro = cnt_ok;
      end
      blk == 7'h19: begin
        sel_inh = (idx == 5'd0);
        sel_evt = evt_ok;
      end
      default: ;
    endcase
  end

  assign cnt_ext = 64'(cnt[idx]);

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_lo:  rdata = cnt_ext[31:0];
      sel_hi:  rdata = cnt_ext[63:32];
      sel_inh: rdata = inh;
      sel_evt: rdata = 32'(evt[idx]);
      default: ;
    endcase
  end

  assign hit     = sel_lo | sel_hi | sel_inh | sel_evt;
  assign does_wr = (op == CSR_WRITE)
                || (((op == CSR_SET) || (op == CSR_CLEAR))
                    && (|csr_wdata_i));

  assign csr_rdata_o   = rdata;
  assign csr_hit_o     = csr_access_i & hit;
  assign csr_illegal_o = csr_hit_o & sel_ro & does_wr;
  assign we            = csr_hit_o & ~sel_ro & does_wr;

  always_comb begin
    unique case (op)
      CSR_SET:   wval = rdata | csr_wdata_i;
      CSR_CLEAR: wval = rdata & ~csr_wdata_i;
      default:   wval = csr_wdata_i;
    endcase
  end

  genvar k;
  generate
    for (k = 0; k < 32; k++) begin : g_cnt
      if (k == 0 || k == 2 || (k >= 3 && k <= LAST)) begin : g_on
        logic                 wr_lo;
        logic                 wr_hi;
        logic                 inc;
        logic [CNT_WIDTH-1:0] q;

        assign wr_lo = we & sel_lo & (idx == 5'(k));
        assign wr_hi = we & sel_hi & (idx == 5'(k));

        if (k == 0) begin : g_cyc
          assign inc = ~inh[0];
`ifdef HPM_OVF_IRQ_EN
          assign wrap[k] = 1'b0;
`endif
        end else if (k == 2) begin : g_ret
          assign inc = instr_retired_i & ~inh[2];
`ifdef HPM_OVF_IRQ_EN
          assign wrap[k] = 1'b0;
`endif
        end else begin : g_hpm
          assign inc = (|(event_i & evt[k])) & ~inh[k];
`ifdef HPM_OVF_IRQ_EN
          assign wrap[k] = inc & ~wr_lo & ~wr_hi & (&q);
`endif
        end

        // A CSR write to either half suppresses the increment
        always_ff @(posedge clk_i or negedge rst_n_i) begin
          if (!rst_n_i) begin
            q <= '0;
          end else if (wr_lo) begin
            q[31:0] <= wval;
          end else if (wr_hi) begin
            q[CNT_WIDTH-1:32] <= wval[HW-1:0];
          end else if (inc) begin
            q <= q + CNT_WIDTH'(1);
          end
        end

        assign cnt[k] = q;
      end else begin : g_off
        assign cnt[k] = '0;
`ifdef HPM_OVF_IRQ_EN
        assign wrap[k] = 1'b0;
`endif
      end
    end

    for (k = 0; k < 32; k++) begin : g_evt
      if (k >= 3 && k <= LAST) begin : g_on
        logic [NUM_EVENTS-1:0] q;

        always_ff @(posedge clk_i or negedge rst_n_i) begin
          if (!rst_n_i) begin
            q <= '0;
          end else if (we & sel_evt & (idx == 5'(k))) begin
            q <= wval[NUM_EVENTS-1:0];
          end
        end

        assign evt[k] = q;
      end else begin : g_off
        assign evt[k] = '0;
      end
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inh <= '0;
    end else if (we & sel_inh) begin
      inh <= wval & INH_MASK;
    end
  end

`ifdef HPM_OVF_IRQ_EN
  // A wrap in the same cycle as an mcountinhibit write keeps the flag set
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ovf_irq_o <= 1'b0;
    end else if (|wrap) begin
      ovf_irq_o <= 1'b1;
    end else if (we & sel_inh) begin
      ovf_irq_o <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_hpm_counters.sv
// Scoreboard bench for hpm_counters against an array-based counter model.
// Builds with or without HPM_OVF_IRQ_EN.
module tb_hpm_counters;
  localparam int NH = 4;
`ifdef HPM_OVF_IRQ_EN
  localparam int CW = 33;
  localparam bit OVF_EN = 1'b1;
`else
  localparam int CW = 40;
  localparam bit OVF_EN = 1'b0;
`endif
  localparam int NE = 8;
  localparam longint unsigned CMASK = (64'd1 << CW) - 64'd1;

  logic          clk = 1'b0;
  logic          rst_n_i;
  logic          csr_access_i;
  logic [11:0]   csr_addr_i;
  logic [1:0]    csr_op_i;
  logic [31:0]   csr_wdata_i;
  logic [31:0]   csr_rdata_o;
  logic          csr_hit_o;
  logic          csr_illegal_o;
  logic          instr_retired_i;
  logic [NE-1:0] event_i;
  logic          ovf_act;

  always #5 clk = ~clk;

`ifdef HPM_OVF_IRQ_EN
  logic ovf_irq_o;
  assign ovf_act = ovf_irq_o;
`else
  assign ovf_act = 1'b0;
`endif

  hpm_counters #(
    .NUM_HPM   (NH),
    .CNT_WIDTH (CW),
    .NUM_EVENTS(NE)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n_i),
    .csr_access_i   (csr_access_i),
    .csr_addr_i     (csr_addr_i),
    .csr_op_i       (csr_op_i),
    .csr_wdata_i    (csr_wdata_i),
    .csr_rdata_o    (csr_rdata_o),
    .csr_hit_o      (csr_hit_o),
    .csr_illegal_o  (csr_illegal_o),
    .instr_retired_i(instr_retired_i),
    .event_i        (event_i)
`ifdef HPM_OVF_IRQ_EN
    ,
    .ovf_irq_o      (ovf_irq_o)
`endif
  );

  typedef struct {
    logic [31:0] rdata;
    bit          hit;
    bit          ill;
    bit          ovf;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;

  longint unsigned m_cnt [32];
  int unsigned     m_evt [32];
  int unsigned     m_inh;
  bit              m_ovf;

  function automatic bit is_evt(int k);
    return k >= 3 && k <= 2 + NH;
  endfunction

  function automatic bit is_cnt(int k);
    return k == 0 || k == 2 || is_evt(k);
  endfunction

  // kind: 0 none, 1 counter low, 2 counter high, 3 inhibit, 4 event
  function automatic void decode(input int a, output int kind,
                                 output int k, output bit ro);
    kind = 0;
    k    = 0;
    ro   = 1'b0;
    if (a >= 'hB00 && a < 'hB20 && is_cnt(a - 'hB00)) begin
      kind = 1; k = a - 'hB00;
    end else if (a >= 'hB80 && a < 'hBA0 && is_cnt(a - 'hB80)) begin
      kind = 2; k = a - 'hB80;
    end else if (a >= 'hC00 && a < 'hC20 && is_cnt(a - 'hC00)) begin
      kind = 1; k = a - 'hC00; ro = 1'b1;
    end else if (a >= 'hC80 && a < 'hCA0 && is_cnt(a - 'hC80)) begin
      kind = 2; k = a - 'hC80; ro = 1'b1;
    end else if (a == 'h320) begin
      kind = 3;
    end else if (a > 'h320 && a < 'h340 && is_evt(a - 'h320)) begin
      kind = 4; k = a - 'h320;
    end
  endfunction

  function automatic logic [31:0] m_read(input int a);
    int kind, k;
    bit ro;
    decode(a, kind, k, ro);
    case (kind)
      1: return 32'(m_cnt[k]);
      2: return 32'(m_cnt[k] >> 32);
      3: return m_inh;
      4: return m_evt[k];
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit m_writes(input int op, input logic [31:0] wd);
    return op == 1 || (op >= 2 && wd != 0);
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) begin
      m_cnt[i] = 0;
      m_evt[i] = 0;
    end
    m_inh = 0;
    m_ovf = 1'b0;
  endfunction

  function automatic void m_update(input bit acc, input int a,
                                   input int op, input logic [31:0] wd,
                                   input bit ir, input logic [NE-1:0] ev);
    longint unsigned nc [32];
    int unsigned     ne [32];
    int unsigned     ni;
    int unsigned     inh_mask;
    int              kind, k, written;
    bit              ro, doit, wrapped, inh_wr, cnt_hit;
    logic [31:0]     old, nv;
    inh_mask = 0;
    for (int b = 0; b < 32; b++)
      if (b == 0 || (b >= 2 && b <= 2 + NH)) inh_mask |= (32'd1 << b);
    nc = m_cnt;
    ne = m_evt;
    ni = m_inh;
    written = -1;
    wrapped = 1'b0;
    inh_wr  = 1'b0;
    decode(a, kind, k, ro);
    doit = acc && kind != 0 && !ro && m_writes(op, wd);
    old  = m_read(a);
    nv   = (op == 1) ? wd : (op == 2) ? (old | wd) : (old & ~wd);
    if (doit) begin
      case (kind)
        1: begin
          nc[k] = (m_cnt[k] & 64'hFFFF_FFFF_0000_0000) | 64'(nv);
          written = k;
        end
        2: begin
          nc[k] = ((64'(nv) << 32) | (m_cnt[k] & 64'hFFFF_FFFF)) & CMASK;
          written = k;
        end
        3: begin
          ni = nv & inh_mask;
          inh_wr = 1'b1;
        end
        default: ne[k] = nv & ((32'd1 << NE) - 1);
      endcase
    end
    for (int c = 0; c < 32; c++) begin
      if (is_cnt(c) && c != written) begin
        if (c == 0)      cnt_hit = !m_inh[0];
        else if (c == 2) cnt_hit = ir && !m_inh[2];
        else             cnt_hit = ((32'(ev) & m_evt[c]) != 0) && !m_inh[c];
        if (cnt_hit) begin
          nc[c] = (m_cnt[c] + 1) & CMASK;
          if (c >= 3 && nc[c] == 0) wrapped = 1'b1;
        end
      end
    end
    m_cnt = nc;
    m_evt = ne;
    m_inh = ni;
    if (OVF_EN && wrapped) m_ovf = 1'b1;
    else if (inh_wr)       m_ovf = 1'b0;
  endfunction

  task automatic step(input bit acc, input int a, input int op,
                      input logic [31:0] wd, input bit ir,
                      input logic [NE-1:0] ev);
    exp_t e;
    int   kind, k;
    bit   ro;
    csr_access_i    = acc;
    csr_addr_i      = 12'(a);
    csr_op_i        = 2'(op);
    csr_wdata_i     = wd;
    instr_retired_i = ir;
    event_i         = ev;
    if (acc) begin
      decode(a, kind, k, ro);
      e.rdata = m_read(a);
      e.hit   = kind != 0;
      e.ill   = kind != 0 && ro && m_writes(op, wd);
      e.ovf   = m_ovf;
      sb.push_back(e);
    end
    @(posedge clk);
    if (rst_n_i) m_update(acc, a, op, wd, ir, ev);
    #1;
  endtask

  task automatic rd(input int a);
    step(1'b1, a, 0, 32'd0, 1'b0, '0);
  endtask

  task automatic wr(input int a, input int op, input logic [31:0] wd);
    step(1'b1, a, op, wd, 1'b0, '0);
  endtask

  task automatic idle(input bit ir, input logic [NE-1:0] ev);
    step(1'b0, 0, 0, 32'd0, ir, ev);
  endtask

  always @(negedge clk) begin
    if (csr_access_i) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty addr=%h got rdata=%h", csr_addr_i, csr_rdata_o);
      end else begin
        me = sb.pop_front();
        if (csr_rdata_o !== me.rdata || csr_hit_o !== me.hit ||
            csr_illegal_o !== me.ill || ovf_act !== me.ovf) begin
          errors++;
          $display("FAIL csr addr=%h op=%0d wd=%h rdata=%h exp=%h hit=%b exp=%b ill=%b exp=%b ovf=%b exp=%b",
                   csr_addr_i, csr_op_i, csr_wdata_i, csr_rdata_o, me.rdata,
                   csr_hit_o, me.hit, csr_illegal_o, me.ill, ovf_act, me.ovf);
        end
      end
    end else begin
      checks++;
      if (csr_hit_o !== 1'b0 || csr_illegal_o !== 1'b0) begin
        errors++;
        $display("FAIL idle_flags addr=%h hit=%b ill=%b exp=0 0",
                 csr_addr_i, csr_hit_o, csr_illegal_o);
      end
    end
  end

  int pool [24] = '{'hB00, 'hB02, 'hB03, 'hB04, 'hB05, 'hB06,
                    'hB80, 'hB82, 'hB83, 'hB86, 'hB07, 'hC00,
                    'hC02, 'hC83, 'hC86, 'h320, 'h323, 'h324,
                    'h325, 'h326, 'h327, 'h321, 'hB01, 'h000};

  initial begin
    int          a, op;
    logic [31:0] wd;
    rst_n_i         = 1'b1;
    csr_access_i    = 1'b0;
    csr_addr_i      = '0;
    csr_op_i        = '0;
    csr_wdata_i     = '0;
    instr_retired_i = 1'b0;
    event_i         = '0;
    m_reset();
    #2 rst_n_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step(1'b1, 'hB00, 1, 32'h1234, 1'b1, '1);
    rd('hB00);
    rd('h320);
    rst_n_i = 1'b1;

    repeat (10) idle(1'b0, '0);
    rd('hB00);
    rd('hB80);
    rd('hB02);

    wr('hB00, 1, 32'hFFFF_FFFF);
    idle(1'b0, '0);
    rd('hB00);
    rd('hB80);

    wr('h323, 1, 32'h05);
    repeat (4) idle(1'b0, 8'h05);
    repeat (3) idle(1'b0, 8'h02);
    rd('hB03);
    rd('h323);

    repeat (3) idle(1'b1, '0);
    step(1'b1, 'hB02, 1, 32'h100, 1'b1, '0);
    step(1'b1, 'hB02, 0, 32'd0, 1'b1, '0);
    wr('h320, 2, 32'h1);
    rd('hB00);
    rd('hB00);
    rd('h320);
    wr('h320, 1, 32'hFFFF_FFFF);
    rd('h320);
    wr('h320, 3, 32'hFFFF_FFFF);
    wr('h320, 2, 32'h0);
    rd('h320);

    wr('hC00, 1, 32'hDEAD);
    rd('hC00);
    wr('hC80, 3, 32'h0);
    wr('hC80, 2, 32'h1);
    rd('hB1F);
    rd('hB01);
    rd('hC01);
    rd('h327);
    wr('h323, 1, 32'hFFFF_FFFF);
    rd('h323);
    wr('hB83, 1, 32'hFFFF_FFFF);
    rd('hB83);

    wr('h323, 1, 32'h01);
    wr('hB03, 1, 32'hFFFF_FFFF);
    wr('hB83, 1, 32'hFFFF_FFFF);
    rd('hB03);
    idle(1'b0, 8'h01);
    rd('hB03);
    rd('hB83);
    wr('h320, 1, 32'h0);
    rd('h320);

    wr('hB04, 1, 32'hFFFF_FFFF);
    wr('hB84, 1, 32'hFFFF_FFFF);
    wr('h324, 1, 32'h80);
    step(1'b1, 'h320, 1, 32'h0, 1'b0, 8'h80);
    rd('hB04);

    idle(1'b0, '0);
    rst_n_i = 1'b0;
    m_reset();
    rd('hB00);
    step(1'b1, 'hB00, 1, 32'h55, 1'b1, '1);
    rd('h323);
    rst_n_i = 1'b1;
    rd('hB00);
    rd('hB00);

    for (int i = 0; i < 400; i++) begin
      a  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4095))
                                       : pool[$urandom_range(0, 23)];
      op = int'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       wd = 32'd0;
        1:       wd = 32'hFFFF_FFFF;
        2:       wd = 32'($urandom_range(0, 255));
        default: wd = $urandom;
      endcase
      if (a == 'h320 && op == 1) wd = wd & 32'h7C;
      step(1'($urandom_range(0, 1)), a, op, wd,
           1'($urandom_range(0, 1)), NE'($urandom));
    end

    for (int i = 0; i < 24; i++) rd(pool[i]);
    idle(1'b0, '0);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain left=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
